// File: rtl/spi_line_cmd_assembler.sv
// spi_line_cmd_assembler
//   Collects 16-bit words from the SPI slave receiver into four-word line
//   commands (x0, y0, x1, y1). Completed commands are buffered in a small
//   FIFO and handed to the line rasterizer over a valid/ready handshake.
//   A partial command is dropped after TIMEOUT idle cycles, which restores
//   word framing after an aborted host transfer.
//
//   Optional feature macro: SPI_CMD_CLAMP_EN
//     defined   : x fields are clamped to H_RES-1 and y fields to V_RES-1
//                 (unsigned) as they are latched.
//     undefined : words are stored unmodified.
//
// Ports
//   clock            in   system clock, rising edge
//   io_aresetn       in   asynchronous active-low reset
//   io_wordValid     in   one-cycle pulse, a received word is complete
//   io_wordData      in   received word (CORDW)
//   io_cmdValid      out  FIFO not empty
//   io_cmdReady      in   rasterizer accepts the head command
//   io_x0..io_y1     out  head command fields (CORDW each)
//   io_busy          out  partial command in progress
//   io_level         out  FIFO occupancy
//   io_overflow      out  sticky, a completed command was dropped
//   io_clearOverflow in   synchronous clear of io_overflow
module spi_line_cmd_assembler #(
  parameter int CORDW      = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 4096,
  parameter int H_RES      = 640,
  parameter int V_RES      = 480
) (
  input  logic                            clock,
  input  logic                            io_aresetn,
  input  logic                            io_wordValid,
  input  logic [CORDW-1:0]                io_wordData,
  output logic                            io_cmdValid,
  input  logic                            io_cmdReady,
  output logic [CORDW-1:0]                io_x0,
  output logic [CORDW-1:0]                io_y0,
  output logic [CORDW-1:0]                io_x1,
  output logic [CORDW-1:0]                io_y1,
  output logic                            io_busy,
  output logic [$clog2(FIFO_DEPTH):0]     io_level,
  output logic                            io_overflow,
  input  logic                            io_clearOverflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [CORDW-1:0] X_MAX = CORDW'(H_RES - 1);
  localparam logic [CORDW-1:0] Y_MAX = CORDW'(V_RES - 1);
  localparam logic [TW-1:0]    TMO_LAST = TW'(TIMEOUT - 1);

`ifdef SPI_CMD_CLAMP_EN
  localparam bit CLAMP_ON = 1'b1;
`else
  localparam bit CLAMP_ON = 1'b0;
`endif

  typedef struct packed {
    logic [CORDW-1:0] x0;
    logic [CORDW-1:0] y0;
    logic [CORDW-1:0] x1;
    logic [CORDW-1:0] y1;
  } cmd_t;

  function automatic logic [CORDW-1:0] clamp_x(input logic [CORDW-1:0] v);
    return (CLAMP_ON && (v > X_MAX)) ? X_MAX : v;
  endfunction

  function automatic logic [CORDW-1:0] clamp_y(input logic [CORDW-1:0] v);
    return (CLAMP_ON && (v > Y_MAX)) ? Y_MAX : v;
  endfunction

  // Framing and partial-command state
  logic [1:0]       widx_q, widx_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic [CORDW-1:0] x0_q, x0_d, y0_q, y0_d, x1_q, x1_d;
  logic             push_s;
  cmd_t             push_cmd_s;

  // FIFO state
  cmd_t             mem_q [FIFO_DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic             ovf_q, ovf_d;
  logic             empty_s, full_s, pop_s, wr_ok_s, ovf_set_s;

  // Word framing and timeout; a word arriving on the expiry cycle wins.
  // The counter expires when it would step to TIMEOUT, so it never holds
  // a value above TIMEOUT-1.
  always_comb begin
    widx_d     = widx_q;
    tmo_d      = tmo_q;
    x0_d       = x0_q;
    y0_d       = y0_q;
    x1_d       = x1_q;
    push_s     = 1'b0;
    push_cmd_s = '{x0: x0_q, y0: y0_q, x1: x1_q, y1: clamp_y(io_wordData)};
    if (io_wordValid) begin
      tmo_d = '0;
      case (widx_q)
        2'd0: begin
          x0_d   = clamp_x(io_wordData);
          widx_d = 2'd1;
        end
        2'd1: begin
          y0_d   = clamp_y(io_wordData);
          widx_d = 2'd2;
        end
        2'd2: begin
          x1_d   = clamp_x(io_wordData);
          widx_d = 2'd3;
        end
        2'd3: begin
          push_s = 1'b1;
          widx_d = 2'd0;
        end
        default: begin
          widx_d = 2'd0;
        end
      endcase
    end else if (widx_q != 2'd0) begin
      if (tmo_q == TMO_LAST) begin
        widx_d = 2'd0;
        tmo_d  = '0;
        x0_d   = '0;
        y0_d   = '0;
        x1_d   = '0;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end else begin
      tmo_d = '0;
    end
  end

  // Framing registers
  always_ff @(posedge clock or negedge io_aresetn) begin
    if (!io_aresetn) begin
      widx_q <= 2'd0;
      tmo_q  <= '0;
      x0_q   <= '0;
      y0_q   <= '0;
      x1_q   <= '0;
    end else begin
      widx_q <= widx_d;
      tmo_q  <= tmo_d;
      x0_q   <= x0_d;
      y0_q   <= y0_d;
      x1_q   <= x1_d;
    end
  end

  // FIFO control: when full, a same-cycle pop frees the slot the push
  // writes into (the tail index equals the departing head index).
  always_comb begin
    empty_s   = (wptr_q == rptr_q);
    full_s    = ((wptr_q ^ rptr_q) == {1'b1, {AW{1'b0}}});
    pop_s     = !empty_s && io_cmdReady;
    wr_ok_s   = push_s && (!full_s || pop_s);
    ovf_set_s = push_s && full_s && !pop_s;
    wptr_d    = wr_ok_s ? (wptr_q + PW'(1)) : wptr_q;
    rptr_d    = pop_s ? (rptr_q + PW'(1)) : rptr_q;
    if (ovf_set_s) begin
      ovf_d = 1'b1;
    end else if (io_clearOverflow) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // FIFO pointers and sticky overflow flag
  always_ff @(posedge clock or negedge io_aresetn) begin
    if (!io_aresetn) begin
      wptr_q <= '0;
      rptr_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      ovf_q  <= ovf_d;
    end
  end

  // FIFO storage; cleared on reset so the coordinate outputs read zero
  always_ff @(posedge clock or negedge io_aresetn) begin
    if (!io_aresetn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (wr_ok_s) begin
        mem_q[wptr_q[AW-1:0]] <= push_cmd_s;
      end
    end
  end

  assign io_cmdValid = !empty_s;
  assign io_x0       = mem_q[rptr_q[AW-1:0]].x0;
  assign io_y0       = mem_q[rptr_q[AW-1:0]].y0;
  assign io_x1       = mem_q[rptr_q[AW-1:0]].x1;
  assign io_y1       = mem_q[rptr_q[AW-1:0]].y1;
  assign io_busy     = (widx_q != 2'd0);
  assign io_level    = wptr_q - rptr_q;
  assign io_overflow = ovf_q;

endmodule

// File: tb/tb_spi_line_cmd_assembler.sv
// Directed self-checking bench for spi_line_cmd_assembler. Expected commands
// are queued when their final word is driven and compared at each pop.
module tb_spi_line_cmd_assembler;

  localparam int CORDW   = 16;
  localparam int DEPTH   = 4;
  localparam int TMO     = 8;

  logic             clock = 1'b0;
  logic             io_aresetn;
  logic             io_wordValid;
  logic [CORDW-1:0] io_wordData;
  logic             io_cmdValid;
  logic             io_cmdReady;
  logic [CORDW-1:0] io_x0, io_y0, io_x1, io_y1;
  logic             io_busy;
  logic [2:0]       io_level;
  logic             io_overflow;
  logic             io_clearOverflow;

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q [$];

  spi_line_cmd_assembler #(
    .CORDW(CORDW), .FIFO_DEPTH(DEPTH), .TIMEOUT(TMO), .H_RES(640), .V_RES(480)
  ) dut (
    .clock(clock), .io_aresetn(io_aresetn),
    .io_wordValid(io_wordValid), .io_wordData(io_wordData),
    .io_cmdValid(io_cmdValid), .io_cmdReady(io_cmdReady),
    .io_x0(io_x0), .io_y0(io_y0), .io_x1(io_x1), .io_y1(io_y1),
    .io_busy(io_busy), .io_level(io_level),
    .io_overflow(io_overflow), .io_clearOverflow(io_clearOverflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drive one word, captured at the next rising edge
  task automatic word(input logic [15:0] w);
    io_wordValid = 1'b1;
    io_wordData  = w;
    tick();
    io_wordValid = 1'b0;
    io_wordData  = 16'h0000;
  endtask

  task automatic cmd4(input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] c, input logic [15:0] d);
    word(a); word(b); word(c); word(d);
  endtask

  // Compare the head against the scoreboard; the caller pops it next edge
  task automatic pop_check(input string tag);
    logic [63:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_valid"}, 64'(io_cmdValid), 64'd1);
      chk({tag, "_head"}, {io_x0, io_y0, io_x1, io_y1}, e);
    end
  endtask

  initial begin
    io_aresetn       = 1'b0;
    io_wordValid     = 1'b0;
    io_wordData      = 16'h0000;
    io_cmdReady      = 1'b0;
    io_clearOverflow = 1'b0;
    #12;
    chk("rst_valid", 64'(io_cmdValid), 64'd0);
    chk("rst_busy", 64'(io_busy), 64'd0);
    chk("rst_level", 64'(io_level), 64'd0);
    chk("rst_ovf", 64'(io_overflow), 64'd0);
    chk("rst_x0", 64'(io_x0), 64'd0);
    @(negedge clock);
    io_aresetn = 1'b1;
    tick();

    // Single command
    io_cmdReady = 1'b1;
    word(16'd0);
    chk("t1_busy", 64'(io_busy), 64'd1);
    word(16'd0); word(16'd100);
    chk("t1_not_valid_early", 64'(io_cmdValid), 64'd0);
    exp_q.push_back({16'd0, 16'd0, 16'd100, 16'd100});
    word(16'd100);
    chk("t1_busy_done", 64'(io_busy), 64'd0);
    chk("t1_level1", 64'(io_level), 64'd1);
    pop_check("t1");
    tick();
    chk("t1_level0", 64'(io_level), 64'd0);
    chk("t1_valid0", 64'(io_cmdValid), 64'd0);

    // Five commands without ready: fifth is dropped
    io_cmdReady = 1'b0;
    for (int n = 1; n <= 5; n++) begin
      if (n <= 4) exp_q.push_back({16'(n), 16'(n), 16'(n), 16'(n)});
      cmd4(16'(n), 16'(n), 16'(n), 16'(n));
      if (n == 4) chk("t2_no_ovf_yet", 64'(io_overflow), 64'd0);
    end
    chk("t2_level4", 64'(io_level), 64'd4);
    chk("t2_ovf", 64'(io_overflow), 64'd1);
    io_cmdReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pop_check("t2");
      tick();
    end
    io_cmdReady = 1'b0;
    chk("t2_drained", 64'(io_level), 64'd0);
    chk("t2_ovf_sticky", 64'(io_overflow), 64'd1);
    io_clearOverflow = 1'b1;
    tick();
    io_clearOverflow = 1'b0;
    chk("t2_ovf_clr", 64'(io_overflow), 64'd0);

    // Push and pop at full
    for (int n = 10; n <= 13; n++) begin
      exp_q.push_back({16'(n), 16'(n), 16'(n), 16'(n)});
      cmd4(16'(n), 16'(n), 16'(n), 16'(n));
    end
    chk("t3_full", 64'(io_level), 64'd4);
    word(16'd14); word(16'd14); word(16'd14);
    io_cmdReady = 1'b1;
    exp_q.push_back({16'd14, 16'd14, 16'd14, 16'd14});
    pop_check("t3_first");
    word(16'd14);
    io_cmdReady = 1'b0;
    chk("t3_level_stays4", 64'(io_level), 64'd4);
    chk("t3_no_ovf", 64'(io_overflow), 64'd0);
    io_cmdReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pop_check("t3");
      tick();
    end
    chk("t3_drained", 64'(io_level), 64'd0);

    // Timeout resync
    word(16'd7); word(16'd8);
    repeat (TMO - 1) tick();
    chk("t4_busy_before_expiry", 64'(io_busy), 64'd1);
    tick();
    chk("t4_busy_expired", 64'(io_busy), 64'd0);
    chk("t4_no_cmd", 64'(io_level), 64'd0);
    exp_q.push_back({16'd1, 16'd2, 16'd3, 16'd4});
    cmd4(16'd1, 16'd2, 16'd3, 16'd4);
    chk("t4_level1", 64'(io_level), 64'd1);
    pop_check("t4");
    tick();

    // Word on the expiry cycle is latched as word 2
    word(16'd20); word(16'd21);
    repeat (TMO - 1) tick();
    word(16'd22);
    chk("t4b_busy", 64'(io_busy), 64'd1);
    exp_q.push_back({16'd20, 16'd21, 16'd22, 16'd23});
    word(16'd23);
    chk("t4b_level1", 64'(io_level), 64'd1);
    pop_check("t4b");
    tick();
    chk("t4b_drained", 64'(io_level), 64'd0);

    // Asynchronous reset mid-assembly with a buffered command
    io_cmdReady = 1'b0;
    cmd4(16'd30, 16'd30, 16'd30, 16'd30);
    word(16'd5); word(16'd6);
    chk("t5_pre_level", 64'(io_level), 64'd1);
    #2;
    io_aresetn = 1'b0;
    #1;
    chk("t5_valid", 64'(io_cmdValid), 64'd0);
    chk("t5_busy", 64'(io_busy), 64'd0);
    chk("t5_level", 64'(io_level), 64'd0);
    chk("t5_x0", 64'(io_x0), 64'd0);
    @(negedge clock);
    io_aresetn = 1'b1;
    tick();
    io_cmdReady = 1'b1;
    exp_q.push_back({16'd9, 16'd9, 16'd9, 16'd9});
    cmd4(16'd9, 16'd9, 16'd9, 16'd9);
    pop_check("t5");
    tick();

    // Clamp (or pass-through) of oversized coordinates
`ifdef SPI_CMD_CLAMP_EN
    exp_q.push_back({16'd639, 16'd479, 16'd639, 16'd479});
`else
    exp_q.push_back({16'd1000, 16'd600, 16'd639, 16'd479});
`endif
    cmd4(16'd1000, 16'd600, 16'd639, 16'd479);
    pop_check("t6");
    tick();
    chk("t6_drained", 64'(io_level), 64'd0);
    chk("sb_empty_end", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
